// File: rtl/ss_msg_scroll_if.sv
// Message scroller bus: message load request in, per-digit decoder codes/enables out.
// The master side loads messages; the slave side (the scroller) drives the digit bank.
interface ss_msg_scroll_if #(
  parameter int NDIGITS = 4,
  parameter int MSG_LEN = 8
);
  localparam int LW = $clog2(MSG_LEN + 1);

  logic                   load;
  logic [LW-1:0]          msg_len;
  logic [5*MSG_LEN-1:0]   msg_data;
  logic                   busy;
  logic                   done;
  logic [5*NDIGITS-1:0]   digit_code;
  logic [NDIGITS-1:0]     digit_en;

  modport master (
    output load, msg_len, msg_data,
    input  busy, done, digit_code, digit_en
  );

  modport slave (
    input  load, msg_len, msg_data,
    output busy, done, digit_code, digit_en
  );
endinterface

// File: rtl/ss_msg_scroll.sv
// Right-to-left message scroller feeding a bank of ssdec2 seven-segment decoders.
// Define SS_SCROLL_LOOP_EN to repeat the pass forever and accept reloads while scrolling.
module ss_msg_scroll #(
  parameter int NDIGITS   = 4,
  parameter int MSG_LEN   = 8,
  parameter int SHIFT_DIV = 50
) (
  input  logic              clk,
  input  logic              nrst,
  ss_msg_scroll_if.slave    bus
);
  localparam int LW = $clog2(MSG_LEN + 1);
  localparam int SW = $clog2(MSG_LEN + NDIGITS + 1);
  localparam int PW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SHIFT_DIV - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MSG_LEN);
  localparam logic [SW-1:0] NDIG_S  = SW'(NDIGITS);

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t                 state_q, state_d;
  logic [5*MSG_LEN-1:0]   msg_q, msg_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          idx_q, idx_d;
  logic [SW-1:0]          step_q, step_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [5*NDIGITS-1:0]   code_q, code_d;
  logic [NDIGITS-1:0]     en_q, en_d;

  logic                   accept, start, fire;
  logic [LW-1:0]          eff_len;
  logic [SW-1:0]          step_inc;
  logic [5*MSG_LEN-1:0]   msg_shifted;
  logic [4:0]             head_code;
  logic                   head_en;
  logic [5*NDIGITS-1:0]   shift_code;
  logic [NDIGITS-1:0]     shift_en;

  assign accept   = bus.load && (bus.msg_len != '0);
  assign eff_len  = (bus.msg_len > LEN_MAX) ? LEN_MAX : bus.msg_len;
  assign fire     = (pre_q == PRE_MAX);
  assign step_inc = step_q + 1'b1;

`ifdef SS_SCROLL_LOOP_EN
  assign start = accept;
`else
  assign start = accept && (state_q == IDLE);
`endif

  // Character entering at the right edge; blank once the message is exhausted.
  assign msg_shifted = msg_q >> (32'(idx_q) * 32'd5);
  assign head_en     = (idx_q < len_q);
  assign head_code   = head_en ? msg_shifted[4:0] : 5'd0;

  assign shift_code[4:0] = head_code;
  assign shift_en[0]     = head_en;
  for (genvar gi = 1; gi < NDIGITS; gi++) begin : g_shift
    assign shift_code[5*gi +: 5] = code_q[5*(gi-1) +: 5];
    assign shift_en[gi]          = en_q[gi-1];
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    len_d   = len_q;
    idx_d   = idx_q;
    step_d  = step_q;
    pre_d   = pre_q;
    code_d  = code_q;
    en_d    = en_q;
    done_d  = 1'b0;
    busy_d  = start || (state_q == SCROLL);

    if (start) begin
      msg_d   = bus.msg_data;
      len_d   = eff_len;
      code_d  = '0;
      en_d    = '0;
      idx_d   = '0;
      step_d  = '0;
      pre_d   = PRE_MAX;
      state_d = SCROLL;
    end else if (state_q == SCROLL) begin
      pre_d = fire ? '0 : pre_q + 1'b1;
      if (fire) begin
        code_d = shift_code;
        en_d   = shift_en;
        if (head_en) begin
          idx_d = idx_q + 1'b1;
        end
        step_d = step_inc;
        // Last char has walked off the left edge: the window is blank now.
        if (step_inc == (SW'(len_q) + NDIG_S)) begin
          done_d = 1'b1;
`ifdef SS_SCROLL_LOOP_EN
          idx_d  = '0;
          step_d = '0;
`else
          state_d = IDLE;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      code_q  <= code_d;
      en_q    <= en_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.digit_code = code_q;
  assign bus.digit_en   = en_q;
endmodule

// File: tb/tb_ss_msg_scroll.sv
// Directed table-driven bench for ss_msg_scroll (4 digits, 8 chars; SHIFT_DIV 3 and 1).
// Expectations switch with SS_SCROLL_LOOP_EN so the same bench covers both builds.
module tb_ss_msg_scroll;
`ifdef SS_SCROLL_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  typedef struct {
    int          off;
    logic [19:0] code;
    logic [3:0]  en;
    logic        busy;
    logic        done;
  } vec_t;

  logic  clk;
  logic  nrst;
  int    checks;
  int    failures;
  string test_name;
  vec_t  tbl[$];

  localparam logic [39:0] ERR_DATA = {25'd0, 5'd20, 5'd20, 5'd14};

  ss_msg_scroll_if #(.NDIGITS(4), .MSG_LEN(8)) ifa ();
  ss_msg_scroll_if #(.NDIGITS(4), .MSG_LEN(8)) ifb ();

  ss_msg_scroll #(.NDIGITS(4), .MSG_LEN(8), .SHIFT_DIV(3)) dut_a (
    .clk (clk),
    .nrst(nrst),
    .bus (ifa)
  );

  ss_msg_scroll #(.NDIGITS(4), .MSG_LEN(8), .SHIFT_DIV(1)) dut_b (
    .clk (clk),
    .nrst(nrst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] pk(input logic [4:0] c3, input logic [4:0] c2,
                                     input logic [4:0] c1, input logic [4:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic add(input int off, input logic [19:0] code, input logic [3:0] en,
                     input logic busy, input logic done);
    vec_t v;
    v.off = off; v.code = code; v.en = en; v.busy = busy; v.done = done;
    tbl.push_back(v);
  endtask

  task automatic drive(input int which, input logic ld, input logic [3:0] len,
                       input logic [39:0] data);
    if (which == 0) begin
      ifa.load = ld; ifa.msg_len = len; ifa.msg_data = data;
    end else begin
      ifb.load = ld; ifb.msg_len = len; ifb.msg_data = data;
    end
  endtask

  task automatic check_vec(input int which, input vec_t v);
    logic [19:0] code;
    logic [3:0]  en;
    logic        busy, done;
    code = (which == 0) ? ifa.digit_code : ifb.digit_code;
    en   = (which == 0) ? ifa.digit_en   : ifb.digit_en;
    busy = (which == 0) ? ifa.busy       : ifb.busy;
    done = (which == 0) ? ifa.done       : ifb.done;
    checks++;
    if (code !== v.code || en !== v.en || busy !== v.busy || done !== v.done) begin
      failures++;
      $display("FAIL %s off=%0d: got code=%h en=%b busy=%b done=%b, want code=%h en=%b busy=%b done=%b",
               test_name, v.off, code, en, busy, done, v.code, v.en, v.busy, v.done);
    end
  endtask

  // Load at edge k, then compare table rows sampled 1ns after edge k+off.
  task automatic run_tbl(input int which, input int last_off, input logic [3:0] len,
                         input logic [39:0] data, input int inj_off,
                         input logic [3:0] inj_len, input logic [39:0] inj_data);
    int ti;
    ti = 0;
    drive(which, 1'b1, len, data);
    @(posedge clk); #1;
    drive(which, 1'b0, len, data);
    for (int off = 0; off <= last_off; off++) begin
      if (off > 0) begin
        if (off == inj_off) drive(which, 1'b1, inj_len, inj_data);
        @(posedge clk); #1;
        if (off == inj_off) drive(which, 1'b0, inj_len, inj_data);
      end
      while (ti < tbl.size() && tbl[ti].off == off) begin
        check_vec(which, tbl[ti]);
        ti++;
      end
    end
    $display("run %s rows=%0d", test_name, ti);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic fill_err();
    tbl.delete();
    add(0,  pk(0, 0, 0, 0),    4'b0000, 1'b1, 1'b0);
    add(1,  pk(0, 0, 0, 14),   4'b0001, 1'b1, 1'b0);
    add(3,  pk(0, 0, 0, 14),   4'b0001, 1'b1, 1'b0);
    add(4,  pk(0, 0, 14, 20),  4'b0011, 1'b1, 1'b0);
    add(7,  pk(0, 14, 20, 20), 4'b0111, 1'b1, 1'b0);
    add(10, pk(14, 20, 20, 0), 4'b1110, 1'b1, 1'b0);
    add(13, pk(20, 20, 0, 0),  4'b1100, 1'b1, 1'b0);
    add(16, pk(20, 0, 0, 0),   4'b1000, 1'b1, 1'b0);
    add(18, pk(20, 0, 0, 0),   4'b1000, 1'b1, 1'b0);
    add(19, pk(0, 0, 0, 0),    4'b0000, 1'b1, 1'b1);
    add(20, pk(0, 0, 0, 0),    4'b0000, LOOP, 1'b0);
    if (LOOP) add(22, pk(0, 0, 0, 14), 4'b0001, 1'b1, 1'b0);
    else      add(22, pk(0, 0, 0, 0),  4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    bit seen_done;
    vec_t z;
    checks = 0;
    failures = 0;
    nrst = 1'b0;
    drive(0, 1'b0, 4'd0, 40'd0);
    drive(1, 1'b0, 4'd0, 40'd0);
    z.off = 0; z.code = '0; z.en = '0; z.busy = 1'b0; z.done = 1'b0;

    // Reset state of both instances
    #2;
    test_name = "reset_a"; check_vec(0, z);
    test_name = "reset_b"; check_vec(1, z);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Test 1: "Err" single pass
    test_name = "err_pass";
    fill_err();
    run_tbl(0, 22, 4'd3, ERR_DATA, -1, 4'd0, 40'd0);

    // Test 2: asynchronous reset mid-scroll
    do_reset();
    test_name = "rst_mid";
    drive(0, 1'b1, 4'd3, ERR_DATA);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd3, ERR_DATA);
    repeat (5) @(posedge clk);
    #1 nrst = 1'b0;
    #1 check_vec(0, z);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ifa.done) seen_done = 1'b1;
    end
    nrst = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (ifa.done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || ifa.busy) begin
      failures++;
      $display("FAIL rst_no_done: got done_seen=%b busy=%b, want done_seen=0 busy=0", seen_done, ifa.busy);
    end
    test_name = "rst_restart";
    fill_err();
    run_tbl(0, 22, 4'd3, ERR_DATA, -1, 4'd0, 40'd0);

`ifndef SS_SCROLL_LOOP_EN
    // Test 3: load during SCROLL is ignored
    do_reset();
    test_name = "load_ignored";
    fill_err();
    run_tbl(0, 22, 4'd3, ERR_DATA, 2, 4'd1, {35'd0, 5'd16});
`endif

    // Test 4a: zero-length load is ignored
    do_reset();
    test_name = "len_zero";
    drive(0, 1'b1, 4'd0, ERR_DATA);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, ERR_DATA);
    check_vec(0, z);
    repeat (4) @(posedge clk);
    #1 check_vec(0, z);

    // Test 4b: msg_len=15 clamps to 8
    test_name = "clamp";
    tbl.delete();
    add(0, pk(0, 0, 0, 0), 4'b0000, 1'b1, 1'b0);
    for (int s = 4; s <= 11; s++) begin
      logic [19:0] c;
      logic [3:0]  e;
      c = '0; e = '0;
      for (int d = 0; d < 4; d++) begin
        int j;
        j = s - 1 - d;
        if (j >= 0 && j < 8) begin
          c[5*d +: 5] = 5'(j);
          e[d] = 1'b1;
        end
      end
      add(1 + 3 * (s - 1), c, e, 1'b1, 1'b0);
    end
    add(33, pk(7, 0, 0, 0), 4'b1000, 1'b1, 1'b0);
    add(34, pk(0, 0, 0, 0), 4'b0000, 1'b1, 1'b1);
    add(35, pk(0, 0, 0, 0), 4'b0000, LOOP, 1'b0);
    run_tbl(0, 35, 4'd15,
            {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, -1, 4'd0, 40'd0);

    // Test 5: SHIFT_DIV=1, single '?' walks one digit per cycle
    do_reset();
    test_name = "div1";
    tbl.delete();
    add(1, pk(0, 0, 0, 23), 4'b0001, 1'b1, 1'b0);
    add(2, pk(0, 0, 23, 0), 4'b0010, 1'b1, 1'b0);
    add(3, pk(0, 23, 0, 0), 4'b0100, 1'b1, 1'b0);
    add(4, pk(23, 0, 0, 0), 4'b1000, 1'b1, 1'b0);
    add(5, pk(0, 0, 0, 0),  4'b0000, 1'b1, 1'b1);
    if (LOOP) add(6, pk(0, 0, 0, 23), 4'b0001, 1'b1, 1'b0);
    else      add(6, pk(0, 0, 0, 0),  4'b0000, 1'b0, 1'b0);
    run_tbl(1, 6, 4'd1, {35'd0, 5'd23}, -1, 4'd0, 40'd0);

`ifdef SS_SCROLL_LOOP_EN
    // Test 6: looping pass, then reload while scrolling
    do_reset();
    test_name = "loop";
    tbl.delete();
    add(10, pk(5, 0, 0, 0), 4'b1000, 1'b1, 1'b0);
    add(13, pk(0, 0, 0, 0), 4'b0000, 1'b1, 1'b1);
    add(14, pk(0, 0, 0, 0), 4'b0000, 1'b1, 1'b0);
    add(16, pk(0, 0, 0, 5), 4'b0001, 1'b1, 1'b0);
    add(28, pk(0, 0, 0, 0), 4'b0000, 1'b1, 1'b1);
    add(31, pk(0, 0, 0, 5), 4'b0001, 1'b1, 1'b0);
    run_tbl(0, 31, 4'd1, {35'd0, 5'd5}, -1, 4'd0, 40'd0);

    do_reset();
    test_name = "loop_reload";
    tbl.delete();
    add(16, pk(0, 0, 0, 5), 4'b0001, 1'b1, 1'b0);
    add(19, pk(0, 0, 5, 0), 4'b0010, 1'b1, 1'b0);
    add(20, pk(0, 0, 0, 0), 4'b0000, 1'b1, 1'b0);
    add(21, pk(0, 0, 0, 9), 4'b0001, 1'b1, 1'b0);
    add(24, pk(0, 0, 9, 0), 4'b0010, 1'b1, 1'b0);
    run_tbl(0, 24, 4'd1, {35'd0, 5'd5}, 20, 4'd1, {35'd0, 5'd9});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
